// File: rtl/sdm_pkg.sv
// Shared definitions for the PCM interpolator and the sigma-delta modulator it feeds.
// Sample width, oversampling ratio and the interpolator FSM encoding live here.
package sdm_pkg;

    localparam int DW       = 16;
    localparam int OSR      = 64;
    localparam int LOG2_OSR = $clog2(OSR);

    typedef logic signed [DW-1:0] sample_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_STARVE
    } state_e;

endpackage

// File: rtl/pcm_interpolator.sv
// Linear PCM interpolator: ramps from the previous sample to the current one over OSR clocks,
// producing one sample per modulator clock, with a one-entry holding buffer for the next sample.
//
// state     | meaning
// ----------+------------------------------------------------------------------
// ST_IDLE   | no sample seen since reset; dout=0, waiting for the first sample
// ST_RUN    | ramping prev -> cur, one step of (cur-prev)/OSR per clock
// ST_STARVE | no sample arrived in time; dout held at cur until nxt is loaded
module pcm_interpolator
    import sdm_pkg::state_e, sdm_pkg::ST_IDLE, sdm_pkg::ST_RUN, sdm_pkg::ST_STARVE;
#(
    parameter int DW  = sdm_pkg::DW,
    parameter int OSR = sdm_pkg::OSR
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [DW-1:0] s_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    output logic signed [DW-1:0] dout,
    output logic                 phase_zero,
    output logic                 underrun,
    input  logic                 underrun_clr
);
    localparam int LW = $clog2(OSR);
    localparam int AW = DW + 1 + LW;

    state_e               state;
    logic signed [DW-1:0] prev;
    logic signed [DW-1:0] cur;
    logic signed [DW-1:0] nxt;
    logic                 nxt_valid;
    logic                 ready_en;
    logic [LW-1:0]        phase;
    logic signed [AW-1:0] acc;

    logic signed [DW:0]   delta;
    logic signed [AW-1:0] acc_sum;
    logic signed [AW-1:0] cur_scaled;
    logic                 last;
    logic                 accept;

    // acc holds prev*OSR + delta*phase, so a plain arithmetic shift gives the floored ramp value
    assign delta      = (DW+1)'(cur) - (DW+1)'(prev);
    assign acc_sum    = acc + AW'(delta);
    assign cur_scaled = AW'(cur) <<< LW;
    assign last       = (phase == LW'(OSR - 1));
    assign s_ready    = ready_en && !nxt_valid;
    assign accept     = s_valid && s_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            prev       <= '0;
            cur        <= '0;
            nxt        <= '0;
            nxt_valid  <= 1'b0;
            ready_en   <= 1'b0;
            phase      <= '0;
            acc        <= '0;
            dout       <= '0;
            phase_zero <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (underrun_clr) begin
                underrun <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        cur        <= s_data;
                        prev       <= '0;
                        phase      <= '0;
                        acc        <= '0;
                        dout       <= '0;
                        phase_zero <= 1'b1;
                        state      <= ST_RUN;
                    end
                end
                ST_RUN, ST_STARVE: begin
                    phase      <= phase + LW'(1);
                    phase_zero <= last;
                    if (accept) begin
                        nxt       <= s_data;
                        nxt_valid <= 1'b1;
                    end
                    if (last) begin
                        // segment boundary: old cur becomes the new start point either way
                        prev <= cur;
                        acc  <= cur_scaled;
                        dout <= cur;
                        if (nxt_valid) begin
                            cur       <= nxt;
                            nxt_valid <= 1'b0;
                            state     <= ST_RUN;
                        end else if (state == ST_RUN) begin
                            underrun <= 1'b1;
                            state    <= ST_STARVE;
                        end
                    end else if (state == ST_RUN) begin
                        acc  <= acc_sum;
                        dout <= DW'(acc_sum >>> LW);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/pcm_interpolator.md
PCM_INTERPOLATOR -- requirements
Module: pcm_interpolator

Interface
REQ-001 SHALL have parameter DW, default 16: PCM sample width, signed two's complement.
REQ-002 SHALL have parameter OSR, default 64: oversampling ratio, power of two (2.8224 MHz / 44.1 kHz).
REQ-003 SHALL have port clk  input  1: single clock, the sdm_modulator clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1: reset, asynchronous, active-high.
REQ-005 SHALL have port s_data  input  DW: signed PCM sample from the upstream source.
REQ-006 SHALL have port s_valid  input  1: s_data valid.
REQ-007 SHALL have port s_ready  output  1: block can accept a sample; transfer occurs when s_valid && s_ready at a clk edge.
REQ-008 SHALL have port dout  output  DW: signed interpolated sample, one per clk, wired to sdm_modulator din.
REQ-009 SHALL have port phase_zero  output  1: high in the cycle where dout equals a segment start sample (phase 0).
REQ-010 SHALL have port underrun  output  1: sticky flag, set on starvation.
REQ-011 SHALL have port underrun_clr  input  1: synchronous clear of underrun.

Function
REQ-012 SHALL hold three sample registers: prev, cur (active segment) and nxt with nxt_valid (one-entry holding buffer).
REQ-013 SHALL drive s_ready = !nxt_valid (registered state only; no combinational path from s_valid).
REQ-014 SHALL keep a phase counter of log2(OSR) bits that increments every clock in RUN and STARVE and wraps OSR-1 -> 0.
REQ-015 SHALL implement the FSM states IDLE, RUN and STARVE.
REQ-016 IDLE: dout=0, phase=0, prev=cur=0; on the first accepted sample S, load cur=S, prev=0, phase=0, and go to RUN on the next edge (S is not written to nxt).
REQ-017 RUN: registered dout at phase k SHALL equal prev + floor((cur-prev)*k/OSR), computed with an accumulator (acc += delta each clock, dout = acc arithmetically shifted right by log2(OSR)).
REQ-018 SHALL size delta = cur-prev at DW+1 bits and acc at DW+1+log2(OSR) bits; dout always lies within [min(prev,cur), max(prev,cur)], so no saturation is needed.
REQ-019 At phase OSR-1 with nxt_valid=1: prev<=cur, cur<=nxt, nxt_valid<=0; the next cycle is phase 0, with dout = old cur exactly.
REQ-020 Simultaneous accept and consume at phase OSR-1 is impossible (s_ready=0 while nxt_valid=1); an accept in the wrap cycle while nxt is empty SHALL be treated as starvation for that boundary.
REQ-021 At phase OSR-1 with nxt_valid=0: prev<=cur, delta=0, set underrun, and go to STARVE; dout holds cur.
REQ-022 STARVE: dout is constant at cur and the phase keeps counting; at phase OSR-1 with nxt_valid=1, perform the REQ-019 load and return to RUN; otherwise remain in STARVE.
REQ-023 phase_zero SHALL be 1 whenever phase==0 in RUN or STARVE, and 0 in IDLE.
REQ-024 underrun_clr SHALL clear underrun; if a set condition occurs in the same cycle, the set wins.

Reset
REQ-025 While rst=1: state=IDLE, phase=0, prev=cur=nxt=0, nxt_valid=0, acc=0, dout=0, underrun=0, s_ready=0.
REQ-026 After rst deasserts, s_ready SHALL be 1 from the first clock edge onward.
REQ-027 Reset asserted mid-segment SHALL discard all buffered samples; no partial segment is resumed.

Structure
REQ-028 Package sdm_pkg SHALL hold DW, OSR, LOG2_OSR, typedef sample_t (signed [DW-1:0]) and the FSM state enum; sdm_modulator shares the same package.
REQ-029 SHALL be a single module with no sub-module; the accumulator is inline.

Verification
REQ-030 Reset, then one sample 16384 and no further samples -> dout ramps 0, 256, ..., 16128 (phase 63), then holds 16384 in STARVE with underrun=1.
REQ-031 Continuous feed of 16384 then -16384 -> at phase 32 of the second segment dout=0; at the following phase 0 dout=-16384 and phase_zero=1.
REQ-032 Extremes 32767 -> -32768 -> dout stays within range, no wrap; at phase 1 dout = 32767 + floor(-65535/64) = 31743.
REQ-033 Upstream holding s_valid=1 constantly -> exactly one accept per OSR clocks in steady state, s_ready never high while nxt_valid=1.
REQ-034 Starve for 3 segments, then supply a sample -> RUN resumes at the next phase 0; underrun stays 1 until underrun_clr pulses; a clr coinciding with a new starvation leaves underrun=1.
REQ-035 Assert rst at phase 20 with nxt_valid=1 -> all outputs 0 immediately (asynchronous), s_ready=0; after release the next sample restarts from IDLE behaviour (REQ-016).
